// File: rtl/axi_csr_arb_if.sv
// axi_csr_arb_if: CSR request/response types plus the grouped AXI-side and CSR-side bus of axi_csr_arb.
package axi_csr_arb_pkg;
    typedef struct packed {
        logic        valid;
        logic        rd_or_wr;
        logic [15:0] addr;
        logic [31:0] data_in;
    } s_csr_req_t;
    typedef struct packed {
        logic        ready;
        logic        error;
        logic [31:0] data_out;
    } s_csr_resp_t;
endpackage

interface axi_csr_arb_if;
    import axi_csr_arb_pkg::*;
    logic        wr_req_valid_i;
    logic        wr_req_ready_o;
    logic [15:0] wr_addr_i;
    logic [31:0] wr_data_i;
    logic        wr_resp_valid_o;
    logic        wr_resp_error_o;
    logic        wr_resp_ready_i;
    logic        rd_req_valid_i;
    logic        rd_req_ready_o;
    logic [15:0] rd_addr_i;
    logic        rd_resp_valid_o;
    logic [31:0] rd_resp_data_o;
    logic        rd_resp_error_o;
    logic        rd_resp_ready_i;
    s_csr_req_t  csr_req_o;
    s_csr_resp_t csr_resp_i;
    modport slave (
        input  wr_req_valid_i, wr_addr_i, wr_data_i, wr_resp_ready_i,
        input  rd_req_valid_i, rd_addr_i, rd_resp_ready_i, csr_resp_i,
        output wr_req_ready_o, wr_resp_valid_o, wr_resp_error_o,
        output rd_req_ready_o, rd_resp_valid_o, rd_resp_data_o, rd_resp_error_o, csr_req_o
    );
    modport master (
        output wr_req_valid_i, wr_addr_i, wr_data_i, wr_resp_ready_i,
        output rd_req_valid_i, rd_addr_i, rd_resp_ready_i, csr_resp_i,
        input  wr_req_ready_o, wr_resp_valid_o, wr_resp_error_o,
        input  rd_req_ready_o, rd_resp_valid_o, rd_resp_data_o, rd_resp_error_o, csr_req_o
    );
endinterface

// File: rtl/axi_csr_arb.sv
// axi_csr_arb: round-robin read/write arbiter sequencing one transaction at a time onto the CSR port.
// Optional AXI_CSR_ARB_TIMEOUT_EN aborts a CSR request not accepted within TIMEOUT_CYCLES.
module axi_csr_arb
    import axi_csr_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic          clk_axi,
    input logic          arst_axi,
    axi_csr_arb_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CSR_WR, WR_RESP, CSR_RD, RD_CAPT, RD_RESP} state_t;
    state_t      state_q, state_d;
    logic        last_wr_q, last_wr_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        grant_wr, grant_rd, in_csr, expired;
`ifdef AXI_CSR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        grant_wr  = bus.wr_req_valid_i && (!bus.rd_req_valid_i || !last_wr_q);
        grant_rd  = bus.rd_req_valid_i && !grant_wr;
        in_csr    = (state_q == CSR_WR) || (state_q == CSR_RD);
`ifdef AXI_CSR_ARB_TIMEOUT_EN
        // counts only the not-ready cycles of a held request; zero everywhere else
        cnt_d     = (in_csr && !bus.csr_resp_i.ready) ? cnt_q + CW'(1) : '0;
        expired   = in_csr && !bus.csr_resp_i.ready && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
        expired   = 1'b0;
`endif
        state_d   = state_q;
        last_wr_d = last_wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    addr_d    = bus.wr_addr_i;
                    data_d    = bus.wr_data_i;
                    last_wr_d = 1'b1;
                    state_d   = CSR_WR;
                end else if (grant_rd) begin
                    addr_d    = bus.rd_addr_i;
                    data_d    = '0;
                    last_wr_d = 1'b0;
                    state_d   = CSR_RD;
                end
            end
            CSR_WR: begin
                if (bus.csr_resp_i.ready) begin
                    err_d   = bus.csr_resp_i.error;
                    state_d = WR_RESP;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = WR_RESP;
                end
            end
            CSR_RD: begin
                if (bus.csr_resp_i.ready) begin
                    state_d = RD_CAPT;
                end else if (expired) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = RD_RESP;
                end
            end
            RD_CAPT: begin
                // read data arrives one cycle after the request is accepted
                err_d   = bus.csr_resp_i.error;
                data_d  = bus.csr_resp_i.error ? '0 : bus.csr_resp_i.data_out;
                state_d = RD_RESP;
            end
            WR_RESP: state_d = bus.wr_resp_ready_i ? IDLE : WR_RESP;
            RD_RESP: state_d = bus.rd_resp_ready_i ? IDLE : RD_RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_axi) begin
        if (arst_axi) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

`ifdef AXI_CSR_ARB_TIMEOUT_EN
    always_ff @(posedge clk_axi) begin
        if (arst_axi) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`endif

    assign bus.wr_req_ready_o     = (state_q == IDLE) && grant_wr;
    assign bus.rd_req_ready_o     = (state_q == IDLE) && grant_rd;
    assign bus.csr_req_o.valid    = in_csr;
    assign bus.csr_req_o.rd_or_wr = (state_q == CSR_WR);
    assign bus.csr_req_o.addr     = in_csr ? addr_q : '0;
    assign bus.csr_req_o.data_in  = (state_q == CSR_WR) ? data_q : '0;
    assign bus.wr_resp_valid_o    = (state_q == WR_RESP);
    assign bus.wr_resp_error_o    = (state_q == WR_RESP) && err_q;
    assign bus.rd_resp_valid_o    = (state_q == RD_RESP);
    assign bus.rd_resp_data_o     = (state_q == RD_RESP) ? data_q : '0;
    assign bus.rd_resp_error_o    = (state_q == RD_RESP) && err_q;
endmodule

// File: tb/tb_axi_csr_arb.sv
// tb_axi_csr_arb: directed table-driven bench for axi_csr_arb with a hand-driven CSR bank.
module tb_axi_csr_arb;
    import axi_csr_arb_pkg::*;
    localparam logic [15:0] RAVENOC_VERSION = 16'h3000;
    localparam logic [15:0] IRQ_RD_MUX      = 16'h3008;
    localparam logic [15:0] UNMAPPED        = 16'hDEAD;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic        csr_err;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;
    vec_t tv[6];

    always #5 clk = ~clk;

    axi_csr_arb_if bus ();
    axi_csr_arb #(.TIMEOUT_CYCLES(16)) dut (.clk_axi(clk), .arst_axi(rst), .bus(bus));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic idle_inputs();
        bus.wr_req_valid_i  = 1'b0;
        bus.rd_req_valid_i  = 1'b0;
        bus.wr_addr_i       = '0;
        bus.wr_data_i       = '0;
        bus.rd_addr_i       = '0;
        bus.wr_resp_ready_i = 1'b1;
        bus.rd_resp_ready_i = 1'b1;
        bus.csr_resp_i      = '0;
    endtask

    task automatic run_txn(input vec_t v, input int csr_wait, input int resp_wait);
        @(negedge clk);
        bus.wr_req_valid_i = v.wr;
        bus.rd_req_valid_i = !v.wr;
        bus.wr_addr_i      = v.addr;
        bus.wr_data_i      = v.data;
        bus.rd_addr_i      = v.addr;
        #1;
        chk("req_ready", v.wr ? bus.wr_req_ready_o : bus.rd_req_ready_o, 1);
        @(negedge clk);
        bus.wr_req_valid_i   = 1'b0;
        bus.rd_req_valid_i   = 1'b0;
        bus.csr_resp_i.ready = (csr_wait == 0);
        bus.csr_resp_i.error = v.wr ? v.csr_err : 1'b0;
        #1;
        chk("csr_req", bus.csr_req_o, {1'b1, v.wr, v.addr, v.wr ? v.data : 32'h0});
        for (int w = 1; w <= csr_wait; w++) begin
            @(negedge clk);
            bus.csr_resp_i.ready = (w == csr_wait);
            #1;
            chk("csr_req_held", bus.csr_req_o, {1'b1, v.wr, v.addr, v.wr ? v.data : 32'h0});
        end
        if (!v.wr) begin
            @(negedge clk);
            bus.csr_resp_i = {1'b0, v.csr_err, v.data};
            #1;
            chk("capt_csr_valid", bus.csr_req_o.valid, 0);
        end
        @(negedge clk);
        bus.csr_resp_i      = '0;
        bus.wr_resp_ready_i = (resp_wait == 0);
        bus.rd_resp_ready_i = (resp_wait == 0);
        bus.wr_req_valid_i  = (resp_wait != 0);
        bus.rd_req_valid_i  = (resp_wait != 0);
        #1;
        if (v.wr) chk("wr_resp", {bus.wr_resp_valid_o, bus.wr_resp_error_o, bus.csr_req_o.valid}, {1'b1, v.exp_err, 1'b0});
        else chk("rd_resp", {bus.rd_resp_valid_o, bus.rd_resp_error_o, bus.rd_resp_data_o}, {1'b1, v.exp_err, v.exp_data});
        for (int w = 1; w <= resp_wait; w++) begin
            @(negedge clk);
            bus.wr_resp_ready_i = (w == resp_wait);
            bus.rd_resp_ready_i = (w == resp_wait);
            #1;
            if (v.wr) chk("wr_resp_held", {bus.wr_resp_valid_o, bus.wr_resp_error_o}, {1'b1, v.exp_err});
            else chk("rd_resp_held", {bus.rd_resp_valid_o, bus.rd_resp_error_o, bus.rd_resp_data_o}, {1'b1, v.exp_err, v.exp_data});
            chk("req_ready_blocked", {bus.wr_req_ready_o, bus.rd_req_ready_o}, 0);
        end
        bus.wr_req_valid_i = 1'b0;
        bus.rd_req_valid_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        vec_t v;
        tv[0] = '{1'b1, IRQ_RD_MUX,      32'h0000_0002, 1'b0, 32'h0,          1'b0};
        tv[1] = '{1'b0, RAVENOC_VERSION, 32'h1122_3344, 1'b0, 32'h1122_3344, 1'b0};
        tv[2] = '{1'b1, RAVENOC_VERSION, 32'h0000_00FF, 1'b1, 32'h0,          1'b1};
        tv[3] = '{1'b0, UNMAPPED,        32'hCAFE_BABE, 1'b1, 32'h0,          1'b1};
        tv[4] = '{1'b1, 16'h3010,        32'hA5A5_A5A5, 1'b0, 32'h0,          1'b0};
        tv[5] = '{1'b0, 16'h3010,        32'h5A5A_0F0F, 1'b0, 32'h5A5A_0F0F, 1'b0};
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_csr_req", bus.csr_req_o, 0);
        chk("reset_outputs", {bus.wr_req_ready_o, bus.rd_req_ready_o, bus.wr_resp_valid_o, bus.wr_resp_error_o,
                              bus.rd_resp_valid_o, bus.rd_resp_error_o, bus.rd_resp_data_o}, 0);
        for (int i = 0; i < 6; i++) run_txn(tv[i], 0, 0);
        // CSR stalls and response backpressure
        v = '{1'b1, 16'h3020, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0};
        run_txn(v, 3, 0);
        v = '{1'b0, 16'h3024, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0};
        run_txn(v, 2, 5);
        // round-robin from reset with both requesters valid
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.wr_req_valid_i   = 1'b1;
        bus.rd_req_valid_i   = 1'b1;
        bus.csr_resp_i.ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            #1;
            while (!(bus.wr_req_ready_o || bus.rd_req_ready_o) && cyc < 10) begin
                @(negedge clk);
                #1;
                cyc++;
            end
            chk("tie_grant", {bus.wr_req_ready_o, bus.rd_req_ready_o}, (k % 2) ? 2'b10 : 2'b01);
            @(negedge clk);
        end
        bus.wr_req_valid_i = 1'b0;
        bus.rd_req_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        // reset while a read is held in CSR_RD
        bus.csr_resp_i     = '0;
        bus.rd_req_valid_i = 1'b1;
        bus.rd_addr_i      = 16'h3004;
        @(negedge clk);
        bus.rd_req_valid_i = 1'b0;
        #1;
        chk("csr_rd_held", {bus.csr_req_o.valid, bus.csr_req_o.rd_or_wr}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_csr_req", bus.csr_req_o, 0);
        chk("rst_mid_outputs", {bus.wr_req_ready_o, bus.rd_req_ready_o, bus.wr_resp_valid_o,
                                bus.rd_resp_valid_o, bus.rd_resp_data_o}, 0);
        bus.wr_req_valid_i = 1'b1;
        bus.rd_req_valid_i = 1'b1;
        #1;
        chk("rst_last_grant", {bus.wr_req_ready_o, bus.rd_req_ready_o}, 2'b01);
        bus.wr_req_valid_i = 1'b0;
        bus.rd_req_valid_i = 1'b0;
        run_txn(tv[0], 0, 0);
        // CSR ready never arrives
        @(negedge clk);
        bus.csr_resp_i     = '0;
        bus.rd_req_valid_i = 1'b1;
        bus.rd_addr_i      = 16'h3030;
        @(negedge clk);
        bus.rd_req_valid_i = 1'b0;
        cyc = 0;
        #1;
        while (bus.csr_req_o.valid && cyc < 100) begin
            cyc++;
            @(negedge clk);
            #1;
        end
`ifdef AXI_CSR_ARB_TIMEOUT_EN
        chk("timeout_cycles", cyc, 16);
        chk("timeout_resp", {bus.rd_resp_valid_o, bus.rd_resp_error_o, bus.rd_resp_data_o}, {1'b1, 1'b1, 32'h0});
`else
        chk("no_timeout_held", {bus.csr_req_o.valid, cyc[7:0]}, {1'b1, 8'd100});
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
